// File: rtl/jtbubl_sysctl_pkg.sv
// ---------------------------------------------------------------------------
// jtbubl_sysctl_pkg
// Shared definitions for the JTBUBL-style system-control block:
//   - wdog_state_t : watchdog FSM encoding (RUN counts frames, HOLD keeps the
//                    main CPU in reset for a fixed number of clocks)
//   - VID_BLACK / VID_FLIP : bit positions inside the video-control write data
// ---------------------------------------------------------------------------
package jtbubl_sysctl_pkg;

   typedef enum logic {
      WDOG_RUN  = 1'b0,
      WDOG_HOLD = 1'b1
   } wdog_state_t;

   localparam int VID_BLACK = 0;
   localparam int VID_FLIP  = 1;

endpackage

// File: rtl/jtbubl_sysctl_irq.sv
// ---------------------------------------------------------------------------
// jtbubl_sysctl_irq
// One vblank interrupt latch. A set strobe pulls the active-low request low on
// the next clock; an acknowledge strobe releases it. When both arrive in the
// same cycle the set wins, so a new vblank is never lost to a late ack.
// Ports:
//   i_clk    in  system clock
//   i_rst_n  in  asynchronous active-low reset (request released)
//   i_set    in  start-of-blank strobe
//   i_ack    in  CPU acknowledge strobe
//   o_irq_n  out interrupt request, active low, level
// ---------------------------------------------------------------------------
module jtbubl_sysctl_irq (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_set,
   input  logic i_ack,
   output logic o_irq_n
);

   logic r_irq_n;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)   r_irq_n <= 1'b1;
      else if (i_set) r_irq_n <= 1'b0;
      else if (i_ack) r_irq_n <= 1'b1;
   end

   assign o_irq_n = r_irq_n;

endmodule

// File: rtl/jtbubl_sysctl.sv
// ---------------------------------------------------------------------------
// jtbubl_sysctl
// System-control block for a JTBUBL-style multi-CPU board: frame watchdog with
// a timed main-CPU reset pulse, ROM bank register, subordinate CPU reset
// releases, video control bits and NIRQ vblank interrupt latches.
//
// Build option: define JTBUBL_SYSCTL_WDOG_EN to include the watchdog. Without
// it, main_rst_n is simply rst_n re-timed to clk (async assert, release on the
// next edge) and wdog_clr, WDOGW and RST_HOLD have no effect.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   LVBL       in   vertical blank, active low
//   wdog_clr   in   watchdog kick strobe
//   bank_we    in   bank register write strobe,  bank_din [BANKW] data
//   sub_we     in   sub reset write strobe,      sub_din  [NSUB]  1 = release
//   vid_we     in   video control write strobe,  vid_din  [2]     {flip, black_n}
//   irq_ack    in   [NIRQ] per-channel acknowledge strobes
//   main_rst_n out  main CPU reset, active low
//   sub_rst_n  out  [NSUB] sub CPU/MCU resets, active low
//   bank       out  [BANKW] current ROM bank
//   black_n    out  screen enable
//   flip       out  screen flip
//   irq_n      out  [NIRQ] vblank interrupts, active low, level
// ---------------------------------------------------------------------------
module jtbubl_sysctl
   import jtbubl_sysctl_pkg::*;
#(
   parameter int BANKW    = 3,
   parameter int NSUB     = 2,
   parameter int NIRQ     = 1,
   parameter int WDOGW    = 8,
   parameter int RST_HOLD = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             LVBL,
   input  logic             wdog_clr,
   input  logic             bank_we,
   input  logic [BANKW-1:0] bank_din,
   input  logic             sub_we,
   input  logic [NSUB-1:0]  sub_din,
   input  logic             vid_we,
   input  logic [1:0]       vid_din,
   input  logic [NIRQ-1:0]  irq_ack,
   output logic             main_rst_n,
   output logic [NSUB-1:0]  sub_rst_n,
   output logic [BANKW-1:0] bank,
   output logic             black_n,
   output logic             flip,
   output logic [NIRQ-1:0]  irq_n
);

   logic             r_lvbl_last;
   logic             w_rise;
   logic             w_fall;
   logic             r_main_rst_n;
   logic [BANKW-1:0] r_bank;
   logic [NSUB-1:0]  r_sub_rst_n;
   logic             r_black_n;
   logic             r_flip;

   // Last LVBL resets high (outside blank) so leaving reset never fakes an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_lvbl_last <= 1'b1;
      else        r_lvbl_last <= LVBL;
   end

   assign w_rise = LVBL & ~r_lvbl_last;   // end of blank: one watchdog frame
   assign w_fall = ~LVBL & r_lvbl_last;   // start of blank: interrupt request

`ifdef JTBUBL_SYSCTL_WDOG_EN
   localparam int               HOLDW     = $clog2(RST_HOLD + 1);
   localparam logic [HOLDW-1:0] HOLD_INIT = HOLDW'(RST_HOLD);

   wdog_state_t      r_state;
   logic [WDOGW-1:0] r_count;
   logic [HOLDW-1:0] r_hold;

   // Reset enters HOLD so the main CPU also gets the full reset pulse at power-up.
   // The MSB of the frame count is the timeout flag; leaving RUN as soon as it
   // sets means the counter can never wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= WDOG_HOLD;
         r_count      <= '0;
         r_hold       <= HOLD_INIT;
         r_main_rst_n <= 1'b0;
      end else begin
         case (r_state)
            WDOG_RUN: begin
               if (r_count[WDOGW-1]) begin
                  r_state      <= WDOG_HOLD;
                  r_hold       <= HOLD_INIT;
                  r_count      <= '0;
                  r_main_rst_n <= 1'b0;
               end else if (wdog_clr) begin
                  r_count <= '0;   // a kick beats a same-cycle frame
               end else if (w_rise) begin
                  r_count <= r_count + WDOGW'(1);
               end
            end
            WDOG_HOLD: begin
               r_count <= '0;
               if (r_hold == HOLDW'(1)) begin
                  r_state      <= WDOG_RUN;
                  r_main_rst_n <= 1'b1;
               end else begin
                  r_hold       <= r_hold - HOLDW'(1);
                  r_main_rst_n <= 1'b0;
               end
            end
            default: begin
               r_state      <= WDOG_HOLD;
               r_hold       <= HOLD_INIT;
               r_main_rst_n <= 1'b0;
            end
         endcase
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_main_rst_n <= 1'b0;
      else        r_main_rst_n <= 1'b1;
   end

   // Watchdog inputs and sizing have no function in this build.
   logic w_unused_wdog;
   assign w_unused_wdog = ^{wdog_clr, w_rise, WDOGW[0], RST_HOLD[0]};
`endif

   // Control registers follow the main CPU: cleared while it is held in reset,
   // and any write strobe seen during that time is discarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bank      <= '0;
         r_sub_rst_n <= '0;
         r_black_n   <= 1'b0;
         r_flip      <= 1'b0;
      end else if (!r_main_rst_n) begin
         r_bank      <= '0;
         r_sub_rst_n <= '0;
         r_black_n   <= 1'b0;
         r_flip      <= 1'b0;
      end else begin
         if (bank_we) r_bank      <= bank_din;
         if (sub_we)  r_sub_rst_n <= sub_din;
         if (vid_we) begin
            r_black_n <= vid_din[VID_BLACK];
            r_flip    <= vid_din[VID_FLIP];
         end
      end
   end

   // Interrupt latches only see rst_n, so subordinate CPUs keep pending requests
   // across a watchdog reset of the main CPU.
   genvar gi;
   generate
      for (gi = 0; gi < NIRQ; gi++) begin : g_irq
         jtbubl_sysctl_irq u_irq (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .i_set   (w_fall),
            .i_ack   (irq_ack[gi]),
            .o_irq_n (irq_n[gi])
         );
      end
   endgenerate

   assign main_rst_n = r_main_rst_n;
   assign sub_rst_n  = r_sub_rst_n;
   assign bank       = r_bank;
   assign black_n    = r_black_n;
   assign flip       = r_flip;

endmodule

// File: tb/tb_jtbubl_sysctl.sv
// ---------------------------------------------------------------------------
// tb_jtbubl_sysctl
// Directed bench for jtbubl_sysctl (BANKW=3 NSUB=2 NIRQ=2 WDOGW=4 RST_HOLD=4).
// Expected values are queued when a step is driven and popped when the DUT
// output is sampled one ns after the active clock edge. Watchdog steps follow
// the JTBUBL_SYSCTL_WDOG_EN build option.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jtbubl_sysctl;

   localparam int BANKW    = 3;
   localparam int NSUB     = 2;
   localparam int NIRQ     = 2;
   localparam int WDOGW    = 4;
   localparam int RST_HOLD = 4;

   logic             clk      = 1'b0;
   logic             rst_n    = 1'b1;
   logic             LVBL     = 1'b1;
   logic             wdog_clr = 1'b0;
   logic             bank_we  = 1'b0;
   logic [BANKW-1:0] bank_din = '0;
   logic             sub_we   = 1'b0;
   logic [NSUB-1:0]  sub_din  = '0;
   logic             vid_we   = 1'b0;
   logic [1:0]       vid_din  = '0;
   logic [NIRQ-1:0]  irq_ack  = '0;

   logic             main_rst_n;
   logic [NSUB-1:0]  sub_rst_n;
   logic [BANKW-1:0] bank;
   logic             black_n;
   logic             flip;
   logic [NIRQ-1:0]  irq_n;

   jtbubl_sysctl #(
      .BANKW    (BANKW),
      .NSUB     (NSUB),
      .NIRQ     (NIRQ),
      .WDOGW    (WDOGW),
      .RST_HOLD (RST_HOLD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .LVBL       (LVBL),
      .wdog_clr   (wdog_clr),
      .bank_we    (bank_we),
      .bank_din   (bank_din),
      .sub_we     (sub_we),
      .sub_din    (sub_din),
      .vid_we     (vid_we),
      .vid_din    (vid_din),
      .irq_ack    (irq_ack),
      .main_rst_n (main_rst_n),
      .sub_rst_n  (sub_rst_n),
      .bank       (bank),
      .black_n    (black_n),
      .flip       (flip),
      .irq_n      (irq_n)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [15:0] exp;
   } sb_t;

   sb_t sb_q[$];
   int  n_vec    = 0;
   int  n_miss   = 0;
   bit  saw_low  = 1'b0;

   task automatic push(input string tag, input logic [15:0] exp);
      sb_t e;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic pop_cmp(input logic [15:0] obs);
      sb_t e;
      if (sb_q.size() == 0) begin
         n_miss++;
         $display("FAIL scoreboard_empty observed=%0h required=none", obs);
      end else begin
         e = sb_q.pop_front();
         n_vec++;
         assert (obs === e.exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (main_rst_n !== 1'b1) saw_low = 1'b1;
      end
   endtask

   // One video frame: two clocks of blank, then the rising edge of LVBL.
   task automatic frame();
      LVBL = 1'b0;
      tick(2);
      LVBL = 1'b1;
      tick(1);
   endtask

   task automatic kick();
      wdog_clr = 1'b1;
      tick(1);
      wdog_clr = 1'b0;
   endtask

   task automatic write_regs(input logic [BANKW-1:0] b, input logic [NSUB-1:0] s,
                             input logic [1:0] v);
      bank_din = b;
      sub_din  = s;
      vid_din  = v;
      bank_we  = 1'b1;
      sub_we   = 1'b1;
      vid_we   = 1'b1;
      tick(1);
      bank_we  = 1'b0;
      sub_we   = 1'b0;
      vid_we   = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL sim_timeout observed=running required=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int n_low;

      // Reset state
      push("rst_main", 16'd0);
      push("rst_bank", 16'd0);
      push("rst_sub", 16'd0);
      push("rst_black", 16'd0);
      push("rst_flip", 16'd0);
      push("rst_irq", 16'd3);
      #2 rst_n = 1'b0;
      #10;
      pop_cmp(16'(main_rst_n));
      pop_cmp(16'(bank));
      pop_cmp(16'(sub_rst_n));
      pop_cmp(16'(black_n));
      pop_cmp(16'(flip));
      pop_cmp(16'(irq_n));
      @(posedge clk);
      #1 rst_n = 1'b1;
      push("main_release", 16'd1);
      tick(5);
      pop_cmp(16'(main_rst_n));

      // Register writes, one-cycle latency
      push("wr_bank", 16'd5);
      push("wr_sub", 16'd2);
      push("wr_flip", 16'd1);
      push("wr_black", 16'd1);
      write_regs(3'd5, 2'b10, 2'b11);
      pop_cmp(16'(bank));
      pop_cmp(16'(sub_rst_n));
      pop_cmp(16'(flip));
      pop_cmp(16'(black_n));

      // Vblank interrupts
      irq_ack = 2'b11;
      push("irq_cleared", 16'd3);
      tick(1);
      irq_ack = 2'b00;
      pop_cmp(16'(irq_n));
      LVBL = 1'b0;
      push("irq_fall", 16'd0);
      tick(1);
      pop_cmp(16'(irq_n));
      irq_ack = 2'b01;
      push("irq_ack0", 16'd1);
      tick(1);
      irq_ack = 2'b00;
      pop_cmp(16'(irq_n));
      LVBL = 1'b1;
      tick(1);
      LVBL    = 1'b0;
      irq_ack = 2'b10;
      push("irq_set_wins", 16'd0);
      tick(1);
      irq_ack = 2'b00;
      pop_cmp(16'(irq_n));
      LVBL = 1'b1;
      tick(1);

`ifdef JTBUBL_SYSCTL_WDOG_EN
      kick();

      // Timeout after 8 frames, main reset low for exactly 4 clocks
      push("wd_pre_timeout", 16'd1);
      repeat (7) frame();
      pop_cmp(16'(main_rst_n));
      frame();
      push("wd_low_cycles", 16'd4);
      push("wd_after_hold", 16'd1);
      n_low = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (main_rst_n === 1'b0) n_low++;
      end
      pop_cmp(16'(n_low));
      pop_cmp(16'(main_rst_n));

      // Regular kicks keep the main CPU running
      saw_low = 1'b0;
      push("kick_no_timeout", 16'd0);
      for (int f = 0; f < 50; f++) begin
         frame();
         if (f % 3 == 2) kick();
      end
      kick();
      pop_cmp(16'(saw_low));

      // Kick on the same cycle as a frame edge leaves the count at zero
      repeat (7) frame();
      saw_low = 1'b0;
      LVBL = 1'b0;
      tick(2);
      LVBL     = 1'b1;
      wdog_clr = 1'b1;
      tick(1);
      wdog_clr = 1'b0;
      push("kick_on_rise", 16'd0);
      repeat (7) frame();
      pop_cmp(16'(saw_low));
      push("kick_count_zero", 16'd0);
      frame();
      tick(1);
      pop_cmp(16'(main_rst_n));
      push("kick_hold_end", 16'd1);
      tick(5);
      pop_cmp(16'(main_rst_n));

      // Control registers clear during HOLD and ignore writes there
      push("pre_hold_bank", 16'd5);
      write_regs(3'd5, 2'b10, 2'b11);
      pop_cmp(16'(bank));
      repeat (8) frame();
      tick(1);
      push("hold_bank", 16'd0);
      push("hold_sub", 16'd0);
      push("hold_black", 16'd0);
      push("hold_flip", 16'd0);
      write_regs(3'd3, 2'b11, 2'b11);
      pop_cmp(16'(bank));
      pop_cmp(16'(sub_rst_n));
      pop_cmp(16'(black_n));
      pop_cmp(16'(flip));
      push("post_hold_main", 16'd1);
      push("post_hold_bank", 16'd0);
      tick(4);
      pop_cmp(16'(main_rst_n));
      pop_cmp(16'(bank));

      // rst_n during HOLD restarts the full hold time
      kick();
      repeat (8) frame();
      tick(2);
      push("irq_kept_in_hold", 16'd0);
      pop_cmp(16'(irq_n));
      push("async_main", 16'd0);
      push("async_irq", 16'd3);
      rst_n = 1'b0;
      #1;
      pop_cmp(16'(main_rst_n));
      pop_cmp(16'(irq_n));
      #1 rst_n = 1'b1;
      push("hold_restart_low", 16'd3);
      push("hold_restart_end", 16'd1);
      n_low = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (main_rst_n === 1'b0) n_low++;
      end
      pop_cmp(16'(n_low));
      pop_cmp(16'(main_rst_n));
`else
      // No watchdog: frames without kicks never reset the main CPU
      saw_low = 1'b0;
      push("nowd_no_reset", 16'd0);
      push("nowd_bank_kept", 16'd5);
      repeat (300) frame();
      pop_cmp(16'(saw_low));
      pop_cmp(16'(bank));
      push("nowd_async_main", 16'd0);
      push("nowd_async_bank", 16'd0);
      rst_n = 1'b0;
      #1;
      pop_cmp(16'(main_rst_n));
      pop_cmp(16'(bank));
      @(posedge clk);
      #1 rst_n = 1'b1;
      push("nowd_release", 16'd1);
      tick(1);
      pop_cmp(16'(main_rst_n));
`endif

      if (sb_q.size() != 0) begin
         n_miss++;
         $display("FAIL scoreboard_leftover observed=%0d required=0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
